// File: rtl/cpu_alu_pkg.sv
// Opcode encodings, sequencer state encoding and counter width shared by the
// ALU, the control unit and the ALU sequencer.
package cpu_alu_pkg;

    localparam logic [4:0] OpLd   = 5'd0;
    localparam logic [4:0] OpLdi  = 5'd1;
    localparam logic [4:0] OpSt   = 5'd2;
    localparam logic [4:0] OpAdd  = 5'd3;
    localparam logic [4:0] OpSub  = 5'd4;
    localparam logic [4:0] OpShr  = 5'd5;
    localparam logic [4:0] OpShra = 5'd6;
    localparam logic [4:0] OpShl  = 5'd7;
    localparam logic [4:0] OpRor  = 5'd8;
    localparam logic [4:0] OpRol  = 5'd9;
    localparam logic [4:0] OpAnd  = 5'd10;
    localparam logic [4:0] OpOr   = 5'd11;
    localparam logic [4:0] OpAddi = 5'd12;
    localparam logic [4:0] OpAndi = 5'd13;
    localparam logic [4:0] OpOri  = 5'd14;
    localparam logic [4:0] OpMul  = 5'd15;
    localparam logic [4:0] OpDiv  = 5'd16;
    localparam logic [4:0] OpNeg  = 5'd17;
    localparam logic [4:0] OpNot  = 5'd18;

    localparam int unsigned CntWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ClassBasic = 2'd0,
        ClassMul   = 2'd1,
        ClassDiv   = 2'd2
    } op_class_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU and response channels of the ALU sequencer. The sequencer takes
// the slave side; the control unit / ALU pair takes the master side.
interface alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_c;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_lo;
    logic [31:0] resp_hi;
    logic        resp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_c, resp_ready,
        output req_ready, alu_op, alu_a, alu_b, resp_valid, resp_lo, resp_hi, resp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_c, resp_ready,
        input  req_ready, alu_op, alu_a, alu_b, resp_valid, resp_lo, resp_hi, resp_err, busy
    );

endinterface

// File: rtl/alu_op_remap.sv
// Maps a CPU instruction opcode onto the ALU function it needs, flags opcodes
// outside the instruction set and classifies the op for latency selection.
module alu_op_remap
    import cpu_alu_pkg::*;
(
    input  logic [4:0] cpu_op,
    output logic [4:0] alu_op,
    output logic       legal,
    output op_class_e  op_class
);

    always_comb begin
        alu_op   = cpu_op;
        legal    = (cpu_op <= OpNot);
        op_class = ClassBasic;
        case (cpu_op)
            // Address arithmetic and the immediate forms reuse the register ALU functions.
            OpLd, OpLdi, OpSt, OpAddi: alu_op = OpAdd;
            OpAndi:                    alu_op = OpAnd;
            OpOri:                     alu_op = OpOr;
            OpMul:                     op_class = ClassMul;
            OpDiv:                     op_class = ClassDiv;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one request at a time to the 64-bit ALU, waits the opcode-dependent
// settle time, captures the result into Z-high/Z-low and returns it.
module alu_sequencer
    import cpu_alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES   = 1,
    parameter int unsigned DIV_CYCLES   = 4,
    parameter int unsigned BASIC_CYCLES = 1
) (
    input  logic clk,
    input  logic clr,
    alu_sequencer_if.slave bus
);

    localparam int unsigned MaxCycles = (1 << CntWidth) - 1;

    if (MUL_CYCLES < 1 || MUL_CYCLES > MaxCycles ||
        DIV_CYCLES < 1 || DIV_CYCLES > MaxCycles ||
        BASIC_CYCLES < 1 || BASIC_CYCLES > MaxCycles) begin : g_bad_cfg
        $error("alu_sequencer: cycle parameters must lie in 1..%0d", MaxCycles);
    end

    localparam logic [CntWidth-1:0] MulInit   = CntWidth'(MUL_CYCLES - 1);
    localparam logic [CntWidth-1:0] DivInit   = CntWidth'(DIV_CYCLES - 1);
    localparam logic [CntWidth-1:0] BasicInit = CntWidth'(BASIC_CYCLES - 1);

    logic [4:0]          remap_op;
    logic                remap_legal;
    op_class_e           remap_class;
    logic [CntWidth-1:0] cnt_init;

    state_e              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [4:0]          op_q;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic [31:0]         lo_q;
    logic [31:0]         hi_q;
    logic                err_q;
    logic                valid_q;

    alu_op_remap u_remap (
        .cpu_op   (bus.req_op),
        .alu_op   (remap_op),
        .legal    (remap_legal),
        .op_class (remap_class)
    );

    always_comb begin
        cnt_init = BasicInit;
        case (remap_class)
            ClassMul: cnt_init = MulInit;
            ClassDiv: cnt_init = DivInit;
            default:  cnt_init = BasicInit;
        endcase
    end

    // Operand latches double as the ALU drivers: they are zero outside EXEC so
    // the ALU sees the ld pass-through with zero operands whenever idle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        if (remap_legal) begin
                            op_q    <= remap_op;
                            a_q     <= bus.req_a;
                            b_q     <= bus.req_b;
                            cnt_q   <= cnt_init;
                            state_q <= StExec;
                        end else begin
                            lo_q    <= '0;
                            hi_q    <= '0;
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StExec: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        hi_q    <= bus.alu_c[63:32];
                        lo_q    <= bus.alu_c[31:0];
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        op_q    <= '0;
                        a_q     <= '0;
                        b_q     <= '0;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_lo    = lo_q;
    assign bus.resp_hi    = hi_q;
    assign bus.resp_err   = err_q;

endmodule
